// File: rtl/exec_stage.sv
// ============================================================================
// exec_stage : registers operands into a combinational ALU, owns the flags,
//              resolves jumps and emits a registered writeback packet.
//              Optional shift-add multiplier: define EXEC_MUL_EN.
// Revision   : 1.0  initial release
// ============================================================================
`default_nettype none

`ifndef OP_NOP
`define OP_NOP 5'd0
`define OP_LD  5'd1
`define OP_STR 5'd2
`define OP_NOT 5'd3
`define OP_AND 5'd4
`define OP_OR  5'd5
`define OP_XOR 5'd6
`define OP_NEG 5'd7
`define OP_ADD 5'd8
`define OP_SUB 5'd9
`define OP_MUL 5'd10
`define OP_DIV 5'd11
`define OP_MOD 5'd12
`define OP_JMP 5'd13
`define OP_JC  5'd14
`define OP_JS  5'd15
`define OP_JO  5'd16
`define OP_JZ  5'd17
`define OP_HLT 5'd18
`endif

module exec_stage #(
  parameter int BITS_DATA = 32,
  parameter int BITS_REG  = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4:0]           in_opcode,
  input  logic [BITS_DATA-1:0] in_a,
  input  logic [BITS_DATA-1:0] in_b,
  input  logic [BITS_REG-1:0]  in_dest,
  output logic [BITS_DATA-1:0] alu_operando_a,
  output logic [BITS_DATA-1:0] alu_operando_b,
  output logic [4:0]           alu_opcode,
  input  logic [BITS_DATA-1:0] alu_resultado,
  input  logic                 alu_C,
  input  logic                 alu_S,
  input  logic                 alu_O,
  input  logic                 alu_Z,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BITS_DATA-1:0] out_result,
  output logic [BITS_REG-1:0]  out_dest,
  output logic                 out_we,
  output logic                 out_branch,
  output logic                 out_illegal,
  output logic                 flag_C,
  output logic                 flag_S,
  output logic                 flag_O,
  output logic                 flag_Z,
  output logic                 halted
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_EXEC = 3'd1;
  localparam logic [2:0] S_OUT  = 3'd2;
  localparam logic [2:0] S_HALT = 3'd3;
`ifdef EXEC_MUL_EN
  localparam logic [2:0] S_MUL  = 3'd4;
  localparam int CNT_W = (BITS_DATA > 1) ? $clog2(BITS_DATA) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BITS_DATA - 1);
`endif

  logic [2:0]           state_q, state_d;
  logic [BITS_DATA-1:0] opa_q, opa_d;
  logic [BITS_DATA-1:0] opb_q, opb_d;
  logic [4:0]           op_q, op_d;
  logic [BITS_REG-1:0]  dest_q, dest_d;
  logic                 out_valid_q, out_valid_d;
  logic [BITS_DATA-1:0] out_result_q, out_result_d;
  logic [BITS_REG-1:0]  out_dest_q, out_dest_d;
  logic                 out_we_q, out_we_d;
  logic                 out_branch_q, out_branch_d;
  logic                 out_illegal_q, out_illegal_d;
  logic [3:0]           flags_q, flags_d;  // {C, S, O, Z}
  logic                 halted_q, halted_d;
  logic                 w_accept;

`ifdef EXEC_MUL_EN
  logic [2*BITS_DATA-1:0] mcand_q, mcand_d;
  logic [2*BITS_DATA-1:0] prod_q, prod_d;
  logic [2*BITS_DATA-1:0] w_prod_next;
  logic [BITS_DATA-1:0]   mplier_q, mplier_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;

  assign w_prod_next = prod_q + (mplier_q[0] ? mcand_q : '0);
`endif

  // In OUT the packet drains and a new instruction enters on the same edge.
  assign in_ready = (state_q == S_IDLE) || ((state_q == S_OUT) && out_ready);
  assign w_accept = in_valid && in_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      opa_q         <= '0;
      opb_q         <= '0;
      op_q          <= `OP_NOP;
      dest_q        <= '0;
      out_valid_q   <= 1'b0;
      out_result_q  <= '0;
      out_dest_q    <= '0;
      out_we_q      <= 1'b0;
      out_branch_q  <= 1'b0;
      out_illegal_q <= 1'b0;
      flags_q       <= 4'b0000;
      halted_q      <= 1'b0;
`ifdef EXEC_MUL_EN
      mcand_q       <= '0;
      prod_q        <= '0;
      mplier_q      <= '0;
      cnt_q         <= '0;
`endif
    end else begin
      state_q       <= state_d;
      opa_q         <= opa_d;
      opb_q         <= opb_d;
      op_q          <= op_d;
      dest_q        <= dest_d;
      out_valid_q   <= out_valid_d;
      out_result_q  <= out_result_d;
      out_dest_q    <= out_dest_d;
      out_we_q      <= out_we_d;
      out_branch_q  <= out_branch_d;
      out_illegal_q <= out_illegal_d;
      flags_q       <= flags_d;
      halted_q      <= halted_d;
`ifdef EXEC_MUL_EN
      mcand_q       <= mcand_d;
      prod_q        <= prod_d;
      mplier_q      <= mplier_d;
      cnt_q         <= cnt_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (in_valid) state_d = S_EXEC;
      S_EXEC: begin
        if (op_q == `OP_HLT) state_d = S_HALT;
        else                 state_d = S_OUT;
`ifdef EXEC_MUL_EN
        if (op_q == `OP_MUL) state_d = S_MUL;
`endif
      end
`ifdef EXEC_MUL_EN
      S_MUL:  if (cnt_q == CNT_LAST) state_d = S_OUT;
`endif
      S_OUT:  if (out_ready) state_d = in_valid ? S_EXEC : S_IDLE;
      S_HALT: state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    opa_d         = opa_q;
    opb_d         = opb_q;
    op_d          = op_q;
    dest_d        = dest_q;
    out_valid_d   = out_valid_q;
    out_result_d  = out_result_q;
    out_dest_d    = out_dest_q;
    out_we_d      = out_we_q;
    out_branch_d  = out_branch_q;
    out_illegal_d = out_illegal_q;
    flags_d       = flags_q;
    halted_d      = halted_q;
`ifdef EXEC_MUL_EN
    mcand_d       = mcand_q;
    prod_d        = prod_q;
    mplier_d      = mplier_q;
    cnt_d         = cnt_q;
`endif

    if (w_accept) begin
      opa_d  = in_a;
      opb_d  = in_b;
      op_d   = in_opcode;
      dest_d = in_dest;
    end

    case (state_q)
      S_EXEC: begin
        out_valid_d   = 1'b1;
        out_dest_d    = dest_q;
        out_result_d  = '0;
        out_we_d      = 1'b0;
        out_branch_d  = 1'b0;
        out_illegal_d = 1'b0;
        case (op_q)
          `OP_NOT, `OP_AND, `OP_OR, `OP_NEG, `OP_ADD, `OP_SUB: begin
            out_result_d = alu_resultado;
            out_we_d     = 1'b1;
            flags_d      = {alu_C, alu_S, alu_O, alu_Z};
          end
          `OP_JMP: begin
            out_result_d = opa_q;
            out_branch_d = 1'b1;
          end
          `OP_JC: begin
            out_result_d = opa_q;
            out_branch_d = flags_q[3];
          end
          `OP_JS: begin
            out_result_d = opa_q;
            out_branch_d = flags_q[2];
          end
          `OP_JO: begin
            out_result_d = opa_q;
            out_branch_d = flags_q[1];
          end
          `OP_JZ: begin
            out_result_d = opa_q;
            out_branch_d = flags_q[0];
          end
          `OP_NOP: ;
          `OP_HLT: begin
            out_valid_d = 1'b0;
            halted_d    = 1'b1;
          end
`ifdef EXEC_MUL_EN
          `OP_MUL: begin
            out_valid_d = 1'b0;
            mcand_d     = {{BITS_DATA{1'b0}}, opa_q};
            mplier_d    = opb_q;
            prod_d      = '0;
            cnt_d       = '0;
          end
`endif
          // ALU output is never trusted for ops this stage cannot execute.
          default: out_illegal_d = 1'b1;
        endcase
      end
`ifdef EXEC_MUL_EN
      S_MUL: begin
        prod_d   = w_prod_next;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          out_valid_d  = 1'b1;
          out_we_d     = 1'b1;
          out_result_d = w_prod_next[BITS_DATA-1:0];
          flags_d      = {|w_prod_next[2*BITS_DATA-1:BITS_DATA],
                          w_prod_next[BITS_DATA-1],
                          |w_prod_next[2*BITS_DATA-1:BITS_DATA],
                          (w_prod_next[BITS_DATA-1:0] == '0)};
        end
      end
`endif
      S_OUT: if (out_ready) out_valid_d = 1'b0;
      default: ;
    endcase
  end

  assign alu_operando_a = opa_q;
  assign alu_operando_b = opb_q;
  assign alu_opcode     = op_q;
  assign out_valid      = out_valid_q;
  assign out_result     = out_result_q;
  assign out_dest       = out_dest_q;
  assign out_we         = out_we_q;
  assign out_branch     = out_branch_q;
  assign out_illegal    = out_illegal_q;
  assign flag_C         = flags_q[3];
  assign flag_S         = flags_q[2];
  assign flag_O         = flags_q[1];
  assign flag_Z         = flags_q[0];
  assign halted         = halted_q;

endmodule

`default_nettype wire

// File: tb/tb_exec_stage.sv
// ============================================================================
// tb_exec_stage : directed scoreboard bench for exec_stage with a reference ALU.
// Revision      : 1.0  initial release
// ============================================================================
`default_nettype none

`ifndef OP_NOP
`define OP_NOP 5'd0
`define OP_LD  5'd1
`define OP_STR 5'd2
`define OP_NOT 5'd3
`define OP_AND 5'd4
`define OP_OR  5'd5
`define OP_XOR 5'd6
`define OP_NEG 5'd7
`define OP_ADD 5'd8
`define OP_SUB 5'd9
`define OP_MUL 5'd10
`define OP_DIV 5'd11
`define OP_MOD 5'd12
`define OP_JMP 5'd13
`define OP_JC  5'd14
`define OP_JS  5'd15
`define OP_JO  5'd16
`define OP_JZ  5'd17
`define OP_HLT 5'd18
`endif

module tb_exec_stage;
  localparam int W = 32;
  localparam int R = 4;

  logic         clk = 1'b0;
  logic         reset_n = 1'b1;
  logic         in_valid, in_ready, out_valid, out_ready;
  logic [4:0]   in_opcode, alu_opcode;
  logic [W-1:0] in_a, in_b, alu_a, alu_b, alu_res, out_result;
  logic [R-1:0] in_dest, out_dest;
  logic         alu_C, alu_S, alu_O, alu_Z;
  logic         out_we, out_branch, out_illegal;
  logic         flag_C, flag_S, flag_O, flag_Z, halted;

  typedef struct packed {
    logic [W-1:0] res;
    logic [R-1:0] dest;
    logic         we;
    logic         br;
    logic         il;
    logic [3:0]   flags;  // {C, S, O, Z}
  } pkt_t;

  pkt_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  exec_stage #(.BITS_DATA(W), .BITS_REG(R)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
    .in_a(in_a), .in_b(in_b), .in_dest(in_dest),
    .alu_operando_a(alu_a), .alu_operando_b(alu_b), .alu_opcode(alu_opcode),
    .alu_resultado(alu_res), .alu_C(alu_C), .alu_S(alu_S), .alu_O(alu_O), .alu_Z(alu_Z),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_dest(out_dest), .out_we(out_we), .out_branch(out_branch), .out_illegal(out_illegal),
    .flag_C(flag_C), .flag_S(flag_S), .flag_O(flag_O), .flag_Z(flag_Z), .halted(halted)
  );

  // Reference ALU; ops the stage must not consume return recognisable garbage.
  always_comb begin
    logic [W:0]   t;
    logic [W-1:0] r;
    logic         c, o, ok;
    t = '0; r = 32'hDEAD_BEEF; c = 1'b1; o = 1'b1; ok = 1'b1;
    case (alu_opcode)
      `OP_NOT: begin r = ~alu_a; c = 1'b0; o = 1'b0; end
      `OP_AND: begin r = alu_a & alu_b; c = 1'b0; o = 1'b0; end
      `OP_OR:  begin r = alu_a | alu_b; c = 1'b0; o = 1'b0; end
      `OP_NEG: begin r = -alu_a; c = (alu_a != '0); o = (alu_a == 32'h8000_0000); end
      `OP_ADD: begin
        t = {1'b0, alu_a} + {1'b0, alu_b}; r = t[W-1:0]; c = t[W];
        o = (alu_a[W-1] == alu_b[W-1]) && (r[W-1] != alu_a[W-1]);
      end
      `OP_SUB: begin
        t = {1'b0, alu_a} - {1'b0, alu_b}; r = t[W-1:0]; c = t[W];
        o = (alu_a[W-1] != alu_b[W-1]) && (r[W-1] != alu_a[W-1]);
      end
      default: ok = 1'b0;
    endcase
    alu_res = r;
    alu_C   = c;
    alu_O   = o;
    alu_S   = ok ? r[W-1] : 1'b1;
    alu_Z   = ok ? (r == '0) : 1'b1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [W-1:0] res, input logic [R-1:0] d, input logic we,
                      input logic br, input logic il, input logic [3:0] fl);
    pkt_t p;
    p.res = res; p.dest = d; p.we = we; p.br = br; p.il = il; p.flags = fl;
    sb.push_back(p);
  endtask

  task automatic pop_check(input string tag);
    pkt_t p;
    n_cmp++;
    assert (sb.size() != 0) else begin
      n_err++;
      $error("FAIL %s_sb: observed packet with empty scoreboard, expected none", tag);
    end
    if (sb.size() != 0) begin
      p = sb.pop_front();
      chk({tag, "_valid"},   out_valid, 1'b1);
      chk({tag, "_result"},  out_result, p.res);
      chk({tag, "_dest"},    out_dest, p.dest);
      chk({tag, "_we"},      out_we, p.we);
      chk({tag, "_branch"},  out_branch, p.br);
      chk({tag, "_illegal"}, out_illegal, p.il);
      chk({tag, "_flags"},   {flag_C, flag_S, flag_O, flag_Z}, p.flags);
    end
  endtask

  // Called at a negedge; returns at the negedge right after the handshake edge.
  task automatic issue(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [R-1:0] d);
    int waited = 0;
    in_valid = 1'b1; in_opcode = op; in_a = a; in_b = b; in_dest = d;
    #1;
    while (!in_ready && waited < 40) begin
      @(negedge clk); #1;
      waited++;
    end
    chk("issue_ready", in_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Expects out_valid low before edge `lat` and high right after it.
  task automatic collect(input string tag, input int lat);
    repeat (lat - 2) @(negedge clk);
    chk({tag, "_early"}, out_valid, 1'b0);
    @(negedge clk);
    chk({tag, "_lat"}, out_valid, 1'b1);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    in_valid = 1'b0; in_opcode = `OP_NOP; in_a = '0; in_b = '0; in_dest = '0;
    out_ready = 1'b1;
    #1 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_flags", {flag_C, flag_S, flag_O, flag_Z}, 4'b0000);
    chk("rst_halted", halted, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_alu_op", alu_opcode, `OP_NOP);
    chk("rst_alu_ops", {alu_a, alu_b}, 64'd0);
    chk("rst_out_misc", {out_we, out_branch, out_illegal, out_result}, 35'd0);
    reset_n = 1'b1;

    // ADD wrap-around: carry and zero set.
    push(32'h0, 4'd3, 1'b1, 1'b0, 1'b0, 4'b1001);
    issue(`OP_ADD, 32'hFFFF_FFFF, 32'h1, 4'd3);
    collect("add", 2);
    pop_check("add");
    chk("add_in_ready_out", in_ready, 1'b1);

    // SUB then back-to-back jumps reading the flags SUB produced.
    push(32'h0, 4'd1, 1'b1, 1'b0, 1'b0, 4'b0001);
    issue(`OP_SUB, 32'd5, 32'd5, 4'd1);
    collect("sub", 2);
    pop_check("sub");
    push(32'h40, 4'd2, 1'b0, 1'b1, 1'b0, 4'b0001);
    issue(`OP_JZ, 32'h40, 32'h0, 4'd2);
    collect("jz", 2);
    pop_check("jz");
    push(32'h80, 4'd2, 1'b0, 1'b0, 1'b0, 4'b0001);
    issue(`OP_JC, 32'h80, 32'h0, 4'd2);
    collect("jc", 2);
    pop_check("jc");
    @(negedge clk);

    // Backpressure: packet held, a waiting instruction must not enter.
    out_ready = 1'b0;
    push(32'h0000_00F0, 4'd4, 1'b1, 1'b0, 1'b0, 4'b0000);
    issue(`OP_AND, 32'h0000_F0F0, 32'h0000_0FF0, 4'd4);
    collect("and", 2);
    in_valid = 1'b1; in_opcode = `OP_OR; in_a = 32'h1; in_b = 32'h0; in_dest = 4'd5;
    repeat (5) begin
      @(negedge clk);
      chk("bp_valid", out_valid, 1'b1);
      chk("bp_result", out_result, 32'h0000_00F0);
      chk("bp_in_ready", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    #1;
    pop_check("and");
    push(32'h1, 4'd5, 1'b1, 1'b0, 1'b0, 4'b0000);
    issue(`OP_OR, 32'h1, 32'h0, 4'd5);
    collect("or", 2);
    pop_check("or");

    // MUL: executed with the option, illegal without it.
`ifdef EXEC_MUL_EN
    push(32'h0, 4'd9, 1'b1, 1'b0, 1'b0, 4'b1011);
    issue(`OP_MUL, 32'h0001_0000, 32'h0001_0000, 4'd9);
    collect("mul", W + 2);
`else
    push(32'h0, 4'd9, 1'b0, 1'b0, 1'b1, 4'b0000);
    issue(`OP_MUL, 32'h0001_0000, 32'h0001_0000, 4'd9);
    collect("mul", 2);
`endif
    pop_check("mul");

    // Signed overflow, then illegal ops must leave these flags alone.
    push(32'h7FFF_FFFF, 4'd6, 1'b1, 1'b0, 1'b0, 4'b1010);
    issue(`OP_ADD, 32'h8000_0000, 32'hFFFF_FFFF, 4'd6);
    collect("addovf", 2);
    pop_check("addovf");
    push(32'h0, 4'd7, 1'b0, 1'b0, 1'b1, 4'b1010);
    issue(`OP_XOR, 32'h1234, 32'h00FF, 4'd7);
    collect("xor", 2);
    pop_check("xor");
    push(32'h0, 4'd8, 1'b0, 1'b0, 1'b1, 4'b1010);
    issue(`OP_DIV, 32'd100, 32'd7, 4'd8);
    collect("div", 2);
    pop_check("div");

    // HLT: no packet, stage absorbs until reset.
    issue(`OP_HLT, 32'h0, 32'h0, 4'd0);
    in_valid = 1'b1; in_opcode = `OP_NOP;
    repeat (5) begin
      @(negedge clk);
      chk("hlt_halted", halted, 1'b1);
      chk("hlt_in_ready", in_ready, 1'b0);
      chk("hlt_out_valid", out_valid, 1'b0);
    end
    in_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("hlt_rst_halted", halted, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;

    // Reset while a packet is held in OUT.
    out_ready = 1'b0;
    push(32'h0, 4'd3, 1'b1, 1'b0, 1'b0, 4'b1001);
    issue(`OP_ADD, 32'hFFFF_FFFF, 32'h1, 4'd3);
    collect("pre_rst", 2);
    chk("pre_rst_flags", {flag_C, flag_S, flag_O, flag_Z}, 4'b1001);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 1'b0);
    chk("mid_rst_flags", {flag_C, flag_S, flag_O, flag_Z}, 4'b0000);
    chk("mid_rst_in_ready", in_ready, 1'b1);
    sb.delete();
    @(negedge clk);
    reset_n = 1'b1;
    out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_valid", out_valid, 1'b0);
    end

    push(32'd5, 4'd10, 1'b1, 1'b0, 1'b0, 4'b0000);
    issue(`OP_ADD, 32'd2, 32'd3, 4'd10);
    collect("final", 2);
    pop_check("final");
    chk("sb_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
